serial_rb_xcvr: RTL and testbench

SERIAL_RB_XCVR -- requirements
Module: serial_rb_xcvr

---
 rtl/serial_rb_pkg.sv | 15 +
 rtl/serial_rb_shreg.sv | 30 +++
 rtl/serial_rb_xcvr.sv | 113 +++++++++++
 tb/tb_serial_rb_xcvr.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_rb_pkg.sv
// serial_rb_pkg: state encoding and frame geometry for serial_rb_xcvr; SERIAL_RB_PARITY_EN appends an even-parity bit
package serial_rb_pkg;
  typedef enum logic [2:0] {IDLE, RD, LOAD, TX, GAP, RX, WR, DONE} state_t;
`ifdef SERIAL_RB_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  function automatic int addr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int frame_w(input int aw, input int dw);
    return aw + dw;
  endfunction
endpackage

// File: rtl/serial_rb_shreg.sv
// serial_rb_shreg: parallel-load shift register with saturating bit counter, shared by transmit and receive
module serial_rb_shreg #(
  parameter int W = 21,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [W-1:0]  din,
  input  logic          shift,
  input  logic          sin,
  output logic [W-1:0]  q,
  output logic [CW-1:0] cnt
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q <= '0;
      cnt <= '0;
    end else if (clr) begin
      q <= '0;
      cnt <= '0;
    end else if (load) begin
      q <= din;
      cnt <= '0;
    end else if (shift && cnt < CW'(W)) begin
      q <= {q[W-2:0], sin};
      cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/serial_rb_xcvr.sv
// serial_rb_xcvr: streams a register bank over a sen/sd serial link or fills it from one; SERIAL_RB_PARITY_EN adds parity and perr
module serial_rb_xcvr import serial_rb_pkg::*; #(
  parameter int DATA_W = 18,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      updown,
  output logic                      done,
  output logic                      rb_rw,
  output logic [addr_w(DEPTH)-1:0]  rb_a,
  output logic [DATA_W-1:0]         rb_d,
  input  logic [DATA_W-1:0]         rb_q,
`ifdef SERIAL_RB_PARITY_EN
  output logic                      perr,
`endif
  inout  wire                       sen,
  inout  wire                       sd
);
  localparam int AW = addr_w(DEPTH);
  localparam int FW = frame_w(AW, DATA_W) + PAR_W;
  localparam int CW = $clog2(FW + 1);
  state_t state;
  logic mode, drv, sen_lo, full, par_ok, ok;
  logic [AW-1:0] wcnt, rx_a;
  logic [DATA_W-1:0] rx_d;
  logic [FW-1:0] q, din;
  logic [CW-1:0] cnt;
  assign rx_a = q[FW-1 -: AW];
  assign rx_d = q[FW-1-AW -: DATA_W];
  assign sen_lo = !sen;
  assign full = cnt == CW'(FW);
`ifdef SERIAL_RB_PARITY_EN
  assign par_ok = !(^q);
  assign din = {wcnt, rb_q, ^{wcnt, rb_q}};
  always_ff @(posedge clk or negedge rst)
    if (!rst) perr <= 1'b0;
    else perr <= state == RX && updown == mode && !sen_lo && full && !par_ok;
`else
  assign par_ok = 1'b1;
  assign din = {wcnt, rb_q};
`endif
  assign ok = full && par_ok && {1'b0, rx_a} < (AW+1)'(DEPTH);
  assign sen = drv ? 1'b0 : 1'bz;
  assign sd = drv ? q[FW-1] : 1'bz;
  serial_rb_shreg #(.W(FW), .CW(CW)) u_shreg (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE || state == WR || (state == RX && !sen_lo && !ok)),
    .load(state == LOAD),
    .din(din),
    .shift(state == TX || (state == RX && sen_lo)),
    .sin(sd),
    .q(q),
    .cnt(cnt)
  );
  // outputs are registered alongside the transition into the state they belong to
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      mode <= 1'b0;
      wcnt <= '0;
      done <= 1'b0;
      rb_rw <= 1'b1;
      rb_a <= '0;
      rb_d <= '0;
      drv <= 1'b0;
    end else begin
      done <= 1'b0;
      rb_rw <= 1'b1;
      rb_a <= '0;
      rb_d <= '0;
      drv <= 1'b0;
      if (state != IDLE && updown != mode) begin
        state <= IDLE;
        wcnt <= '0;
      end else
        case (state)
          IDLE: begin
            mode <= updown;
            wcnt <= '0;
            state <= updown ? RD : RX;
          end
          RD: state <= LOAD;
          LOAD: begin
            drv <= 1'b1;
            state <= TX;
          end
          TX: begin
            drv <= cnt != CW'(FW - 1);
            state <= cnt == CW'(FW - 1) ? GAP : TX;
          end
          GAP: begin
            done <= wcnt == AW'(DEPTH - 1);
            rb_a <= wcnt + AW'(1);
            wcnt <= wcnt == AW'(DEPTH - 1) ? wcnt : wcnt + AW'(1);
            state <= wcnt == AW'(DEPTH - 1) ? DONE : RD;
          end
          RX: if (!sen_lo && ok) begin
            rb_rw <= 1'b0;
            rb_a <= rx_a;
            rb_d <= rx_d;
            state <= WR;
          end
          WR: begin
            done <= wcnt == AW'(DEPTH - 1);
            wcnt <= wcnt + AW'(1);
            state <= wcnt == AW'(DEPTH - 1) ? DONE : RX;
          end
          DONE: done <= 1'b1;
        endcase
    end
endmodule

// File: tb/tb_serial_rb_xcvr.sv
// tb_serial_rb_xcvr: directed self-checking bench for serial_rb_xcvr (DATA_W=18, DEPTH=8), honours SERIAL_RB_PARITY_EN
module tb_serial_rb_xcvr;
`ifdef SERIAL_RB_PARITY_EN
  localparam int FW = 22;
`else
  localparam int FW = 21;
`endif
  localparam int LAST = 1 + 8 * (FW + 3);
  logic clk = 1'b0, rst = 1'b0, updown = 1'b1, tb_en = 1'b0, tb_sd = 1'b0;
  logic done, rb_rw;
  logic [2:0] rb_a;
  logic [17:0] rb_d, rb_q;
  logic [17:0] mem [8];
  logic [2:0] wr_a;
  logic [17:0] wr_d;
  int wr_n = 0, perr_n = 0, tests = 0, fails = 0;
  wire sen, sd;
  pullup (sen);
  pullup (sd);
  assign sen = tb_en ? 1'b0 : 1'bz;
  assign sd = tb_en ? tb_sd : 1'bz;
`ifdef SERIAL_RB_PARITY_EN
  logic perr;
  always @(posedge clk) if (perr) perr_n <= perr_n + 1;
`endif
  serial_rb_xcvr #(.DATA_W(18), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .updown(updown), .done(done), .rb_rw(rb_rw), .rb_a(rb_a), .rb_d(rb_d), .rb_q(rb_q),
`ifdef SERIAL_RB_PARITY_EN
    .perr(perr),
`endif
    .sen(sen), .sd(sd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    rb_q <= mem[rb_a];
    if (!rb_rw) begin
      mem[rb_a] <= rb_d;
      wr_a <= rb_a;
      wr_d <= rb_d;
      wr_n <= wr_n + 1;
    end
  end

  function automatic logic [FW-1:0] mk(input logic [2:0] a, input logic [17:0] d);
`ifdef SERIAL_RB_PARITY_EN
    return {a, d, ^{a, d}};
`else
    return {a, d};
`endif
  endfunction

  task automatic send_frame(input logic [FW-1:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tb_en = 1'b1;
      tb_sd = i < FW ? f[FW-1-i] : 1'b1;
    end
    @(negedge clk);
    tb_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (rb_rw !== 1'b1) begin fails++; $display("FAIL reset_rb_rw got %b want 1", rb_rw); end
    tests++; if (rb_a !== 3'd0) begin fails++; $display("FAIL reset_rb_a got %0d want 0", rb_a); end
    tests++; if (rb_d !== 18'd0) begin fails++; $display("FAIL reset_rb_d got %h want 0", rb_d); end
    tests++; if (sen !== 1'b1) begin fails++; $display("FAIL reset_sen got %b want released", sen); end
  endtask

  task automatic test_tx;
    logic [FW-1:0] cur = '0;
    int nb = 0, fi = 0;
    for (int i = 0; i < 8; i++) mem[i] = 18'(i * 18'h1111);
    updown = 1'b1;
    rst = 1'b1;
    for (int k = 1; k <= LAST + 2; k++) begin
      @(negedge clk);
      if (k == 2) begin tests++; if (sen !== 1'b1) begin fails++; $display("FAIL tx_pre_start sen got %b want 1", sen); end end
      if (k == 3) begin tests++; if (sen !== 1'b0) begin fails++; $display("FAIL tx_start sen got %b want 0", sen); end end
      if (k == LAST - 1) begin tests++; if (done !== 1'b0) begin fails++; $display("FAIL tx_done_early got %b want 0", done); end end
      if (k == LAST) begin tests++; if (done !== 1'b1) begin fails++; $display("FAIL tx_done got %b want 1", done); end end
      if (sen === 1'b0) begin
        cur = {cur[FW-2:0], sd};
        nb++;
      end else if (nb > 0) begin
        tests++; if (nb != FW) begin fails++; $display("FAIL tx_len frame %0d got %0d want %0d", fi, nb, FW); end
        tests++; if (cur !== mk(3'(fi), 18'(fi * 18'h1111))) begin fails++; $display("FAIL tx_frame %0d got %h want %h", fi, cur, mk(3'(fi), 18'(fi * 18'h1111))); end
        fi++;
        nb = 0;
        cur = '0;
      end
    end
    tests++; if (fi != 8) begin fails++; $display("FAIL tx_count got %0d want 8", fi); end
  endtask

  task automatic test_rx;
    int base;
    updown = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rx_restart_done got %b want 0", done); end
    base = wr_n;
    for (int i = 0; i < 8; i++) begin
      send_frame(mk(3'(7 - i), 18'h2AAAA), FW);
      tests++; if (wr_n != base + i + 1) begin fails++; $display("FAIL rx_wr_n frame %0d got %0d want %0d", i, wr_n, base + i + 1); end
      tests++; if (wr_a !== 3'(7 - i) || wr_d !== 18'h2AAAA) begin fails++; $display("FAIL rx_wr frame %0d got %0d/%h want %0d/2aaaa", i, wr_a, wr_d, 7 - i); end
    end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL rx_done got %b want 1", done); end
    send_frame(mk(3'd2, 18'h11111), FW);
    tests++; if (wr_n != base + 8) begin fails++; $display("FAIL rx_in_done wr_n got %0d want %0d", wr_n, base + 8); end
  endtask

  task automatic test_abort_truncated;
    int base = wr_n;
    updown = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (sen !== 1'b0) begin fails++; $display("FAIL abort_pre sen got %b want 0", sen); end
    updown = 1'b0;
    @(negedge clk);
    tests++; if (sen !== 1'b1) begin fails++; $display("FAIL abort_release sen got %b want 1", sen); end
    @(negedge clk);
    send_frame(mk(3'd3, 18'h3C3C3), 15);
    tests++; if (wr_n != base) begin fails++; $display("FAIL truncated wr_n got %0d want %0d", wr_n, base); end
    send_frame(mk(3'd5, 18'h12345), FW);
    tests++; if (wr_n != base + 1 || wr_a !== 3'd5 || wr_d !== 18'h12345) begin fails++; $display("FAIL after_trunc got n=%0d %0d/%h want n=%0d 5/12345", wr_n, wr_a, wr_d, base + 1); end
    send_frame(mk(3'd6, 18'h0F0F0), FW + 2);
    tests++; if (wr_n != base + 2 || wr_a !== 3'd6 || wr_d !== 18'h0F0F0) begin fails++; $display("FAIL overlong got n=%0d %0d/%h want n=%0d 6/0f0f0", wr_n, wr_a, wr_d, base + 2); end
  endtask

  task automatic test_reset_mid_tx;
    logic [FW-1:0] cur = '0;
    int nb = 0;
    rst = 1'b0;
    updown = 1'b1;
    @(negedge clk);
    mem[0] = 18'h2ABCD;
    rst = 1'b1;
    repeat (12) @(negedge clk);
    tests++; if (sen !== 1'b0) begin fails++; $display("FAIL mid_tx sen got %b want 0", sen); end
    #1 rst = 1'b0;
    #1;
    tests++; if (sen !== 1'b1 || rb_rw !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL async_reset sen/rw/done got %b%b%b want 110", sen, rb_rw, done); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 40 && !(nb > 0 && sen === 1'b1); k++) begin
      @(negedge clk);
      if (sen === 1'b0) begin
        cur = {cur[FW-2:0], sd};
        nb++;
      end
    end
    tests++; if (nb != FW || cur !== mk(3'd0, 18'h2ABCD)) begin fails++; $display("FAIL restart_frame got %0d bits %h want %0d bits %h", nb, cur, FW, mk(3'd0, 18'h2ABCD)); end
  endtask

`ifdef SERIAL_RB_PARITY_EN
  task automatic test_parity;
    int base = wr_n;
    updown = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(mk(3'd4, 18'h15555) ^ FW'(1), FW);
    tests++; if (wr_n != base) begin fails++; $display("FAIL parity_nowrite wr_n got %0d want %0d", wr_n, base); end
    tests++; if (perr_n != 1) begin fails++; $display("FAIL parity_perr got %0d want 1", perr_n); end
    send_frame(mk(3'd4, 18'h15555), FW);
    tests++; if (wr_n != base + 1 || perr_n != 1) begin fails++; $display("FAIL parity_good got n=%0d perr=%0d want n=%0d perr=1", wr_n, perr_n, base + 1); end
  endtask
`endif

  initial begin
    test_reset;
    test_tx;
    test_rx;
    test_abort_truncated;
    test_reset_mid_tx;
`ifdef SERIAL_RB_PARITY_EN
    test_parity;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
